// File: rtl/fa_selftest.sv
// Built-in self-test sequencer for a single full-adder: drives all eight input
// vectors, checks sum/carry after a settle window and records per-vector failures.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | driving vectors and sampling the adder response
// DONE    | run complete, results held until the next start
module fa_selftest #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       fa_a,
  output logic       fa_b,
  output logic       fa_c,
  input  logic       fa_sum,
  input  logic       fa_carry,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

  logic [1:0] state;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic       exp_sum;
  logic       exp_carry;
  logic       vec_bad;
  logic       sample_now;

  // Reference is taken from idx, not from the registered operand pins.
  assign exp_sum    = idx[2] ^ idx[1] ^ idx[0];
  assign exp_carry  = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
  assign vec_bad    = (fa_sum != exp_sum) || (fa_carry != exp_carry);
  assign sample_now = (state == ST_RUN) && (settle_cnt == 4'd0);

  assign pass = done && (err_count == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      settle_cnt <= 4'd0;
      fa_a       <= 1'b0;
      fa_b       <= 1'b0;
      fa_c       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= 4'd0;
      fail_vec   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RUN;
            idx        <= 3'd0;
            settle_cnt <= SETTLE_LOAD;
            {fa_a, fa_b, fa_c} <= 3'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= 4'd0;
            fail_vec   <= 8'd0;
          end
        end
        ST_RUN: begin
          if (sample_now) begin
            if (vec_bad) begin
              err_count     <= err_count + 4'd1;
              fail_vec[idx] <= 1'b1;
            end
            if (idx == 3'd7) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              {fa_a, fa_b, fa_c} <= 3'd0;
            end else begin
              idx        <= idx + 3'd1;
              settle_cnt <= SETTLE_LOAD;
              {fa_a, fa_b, fa_c} <= idx + 3'd1;
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_selftest.sv
// Scoreboard bench for fa_selftest: two instances (SETTLE=1 and SETTLE=3) driving
// a behavioural full-adder with selectable faults.
module tb_fa_selftest;

  typedef struct {
    int         dut;
    int         acc;
    int         err;
    logic [7:0] fv;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] fa_a, fa_b, fa_c, fa_sum, fa_carry, busy, done, pass;
  logic [3:0] err_count [2];
  logic [7:0] fail_vec [2];

  int         mode [2];
  logic [7:0] sflip [2];
  logic [7:0] cflip [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t e;
  bit   done_q [2];
  bit   held [2];
  int   last_err [2];
  int   last_fv [2];
  int   k, lim;
  bit   act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fa_selftest #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .fa_a(fa_a[0]), .fa_b(fa_b[0]), .fa_c(fa_c[0]),
    .fa_sum(fa_sum[0]), .fa_carry(fa_carry[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .fail_vec(fail_vec[0])
  );

  fa_selftest #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .fa_a(fa_a[1]), .fa_b(fa_b[1]), .fa_c(fa_c[1]),
    .fa_sum(fa_sum[1]), .fa_carry(fa_carry[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .fail_vec(fail_vec[1])
  );

  // mode: 0 good, 1 carry stuck at 0, 2 sum inverted, 3 per-vector flip masks
  function automatic logic [1:0] fa_model(int m, logic [7:0] sf, logic [7:0] cf, logic [2:0] v);
    int   ones;
    logic s, c;
    ones = $countones(v);
    s = (ones % 2) == 1;
    c = ones >= 2;
    case (m)
      1: c = 1'b0;
      2: s = ~s;
      3: begin s = s ^ sf[v]; c = c ^ cf[v]; end
      default: ;
    endcase
    return {s, c};
  endfunction

  always_comb begin
    fa_sum   = '0;
    fa_carry = '0;
    for (int i = 0; i < 2; i++)
      {fa_sum[i], fa_carry[i]} = fa_model(mode[i], sflip[i], cflip[i], {fa_a[i], fa_b[i], fa_c[i]});
  end

  function automatic exp_t expect_run(int i, int acc);
    exp_t       r;
    logic [2:0] vv;
    logic [1:0] m;
    int         ones;
    r.dut = i;
    r.acc = acc;
    r.err = 0;
    r.fv  = 8'd0;
    for (int v = 0; v < 8; v++) begin
      vv   = 3'(v);
      m    = fa_model(mode[i], sflip[i], cflip[i], vv);
      ones = $countones(vv);
      if ((m[1] != ((ones % 2) == 1)) || (m[0] != (ones >= 2))) begin
        r.fv[v] = 1'b1;
        r.err++;
      end
    end
    return r;
  endfunction

  task automatic chk(string nm, int act_v, int exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  task automatic chk_zero(int i, string tag);
    chk({tag, "_vec"},  int'({fa_a[i], fa_b[i], fa_c[i]}), 0);
    chk({tag, "_busy"}, int'(busy[i]), 0);
    chk({tag, "_done"}, int'(done[i]), 0);
    chk({tag, "_pass"}, int'(pass[i]), 0);
    chk({tag, "_err"},  int'(err_count[i]), 0);
    chk({tag, "_fv"},   int'(fail_vec[i]), 0);
  endtask

  task automatic issue(int i, bit rel);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    start[i] = 1'b1;
    q.push_back(expect_run(i, cyc + 1));
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic pulse_start(int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    for (int n = 0; n < budget && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      chk("run_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Monitor: per-cycle vector/flag checks and end-of-run scoreboard compare.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        held[i]   = 1'b0;
        done_q[i] = 1'b0;
        continue;
      end
      lim = (i == 0) ? 16 : 32;
      act = (q.size() > 0) && (q[0].dut == i);
      k   = act ? cyc - q[0].acc : -1;
      if (done[i] && !done_q[i]) begin
        if (!act || k < 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", k, lim);
          chk("err_count", int'(err_count[i]), e.err);
          chk("fail_vec", int'(fail_vec[i]), int'(e.fv));
          chk("pass", int'(pass[i]), (e.err == 0) ? 1 : 0);
          chk("busy_at_done", int'(busy[i]), 0);
          chk("vec_at_done", int'({fa_a[i], fa_b[i], fa_c[i]}), 0);
          held[i]     = 1'b1;
          last_err[i] = e.err;
          last_fv[i]  = int'(e.fv);
        end
      end else if (act && k >= 0 && k < lim) begin
        held[i] = 1'b0;
        chk("busy_run", int'(busy[i]), 1);
        chk("done_run", int'(done[i]), 0);
        chk("vector", int'({fa_a[i], fa_b[i], fa_c[i]}), k / (lim / 8));
        if (k == 0) begin
          chk("err_cleared", int'(err_count[i]), 0);
          chk("fv_cleared", int'(fail_vec[i]), 0);
        end
      end else if (act && k >= lim) begin
        chk("done_missing", int'(done[i]), 1);
        void'(q.pop_front());
      end else if (held[i] && done[i]) begin
        chk("err_hold", int'(err_count[i]), last_err[i]);
        chk("fv_hold", int'(fail_vec[i]), last_fv[i]);
      end
      if (!done[i]) chk("pass_low", int'(pass[i]), 0);
      done_q[i] = done[i];
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 2'b00;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; sflip[i] = 8'd0; cflip[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "reset1");
    chk_zero(1, "reset3");
    rst_n = 1'b1;

    issue(0, 1'b0);
    wait_idle(100);
    repeat (4) @(negedge clk);

    mode[0] = 1;
    issue(0, 1'b0);
    wait_idle(100);

    mode[0] = 2;
    issue(0, 1'b0);
    wait_idle(100);

    mode[0] = 0;
    issue(0, 1'b0);
    repeat (4) @(negedge clk);
    pulse_start(0);
    wait_idle(100);

    for (int r = 0; r < 8; r++) begin
      mode[0]  = 3;
      sflip[0] = 8'($urandom);
      cflip[0] = 8'($urandom);
      issue(0, 1'b0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      pulse_start(0);
      wait_idle(100);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    mode[0] = 0;
    issue(0, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk_zero(0, "abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("idle_busy", int'(busy[0]), 0);
      chk("idle_done", int'(done[0]), 0);
    end
    rst_n = 1'b0;
    issue(0, 1'b1);
    wait_idle(100);

    issue(1, 1'b0);
    wait_idle(200);
    repeat (3) @(negedge clk);
    mode[1] = 1;
    issue(1, 1'b0);
    wait_idle(200);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
